// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared types and constants for the MEM pipeline stage
//
// Purpose: memory-op encoding, commit-info bit positions, FSM state type and
//          the bundle of per-instruction results latched for MEM_WB.
// Ports:   none (package)

package mem_access_stage_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        LD_B  = 4'd1,
        LD_BU = 4'd2,
        LD_H  = 4'd3,
        LD_HU = 4'd4,
        LD_W  = 4'd5,
        ST_B  = 4'd6,
        ST_H  = 4'd7,
        ST_W  = 4'd8
    } mem_op_t;

    // ld_valid bit positions
    localparam int LDV_B  = 0;
    localparam int LDV_BU = 1;
    localparam int LDV_H  = 2;
    localparam int LDV_HU = 3;
    localparam int LDV_W  = 4;

    // st_valid bit positions
    localparam int STV_B = 0;
    localparam int STV_H = 1;
    localparam int STV_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } mas_state_t;

    // Everything MEM_WB and the LSU commit interface see for one instruction.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rw_data;
        logic [4:0]  rw_addr;
        logic        rw_en;
        logic        ram_rd_en;
        logic [7:0]  ld_valid;
        logic [31:0] ld_paddr;
        logic [7:0]  st_valid;
        logic [31:0] st_paddr;
        logic [31:0] st_data;
    } mem_out_t;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_access_stage_lsu_align.sv
// rtl/mem_access_stage_lsu_align.sv - combinational load/store data alignment
//
// Purpose: decodes the memory op, shapes store strobes/data, extracts and
//          extends load data, and flags misaligned addresses.
// Ports:
//   mem_op_i      memory operation
//   addr_lo_i     effective address bits [1:0]
//   st_data_i     store source register
//   rdata_i       raw load word from the data RAM
//   is_load_o     op is a load
//   is_store_o    op is a store
//   misaligned_o  address not naturally aligned for the access size
//   wstrb_o       byte strobes (0 for non-stores)
//   wdata_o       lane-replicated store data (0 for non-stores)
//   ld_value_o    aligned and extended load value
//   ld_onehot_o   ld_valid encoding of the op
//   st_onehot_o   st_valid encoding of the op

import mem_access_stage_pkg::*;

module lsu_align (
    input  mem_op_t     mem_op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rdata_i,
    output logic        is_load_o,
    output logic        is_store_o,
    output logic        misaligned_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_value_o,
    output logic [7:0]  ld_onehot_o,
    output logic [7:0]  st_onehot_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        is_load_o    = 1'b0;
        is_store_o   = 1'b0;
        misaligned_o = 1'b0;
        wstrb_o      = 4'b0000;
        wdata_o      = 32'h0;
        ld_value_o   = 32'h0;
        ld_onehot_o  = 8'h00;
        st_onehot_o  = 8'h00;
        case (mem_op_i)
            LD_B: begin
                is_load_o          = 1'b1;
                ld_value_o         = {{24{shifted[7]}}, shifted[7:0]};
                ld_onehot_o[LDV_B] = 1'b1;
            end
            LD_BU: begin
                is_load_o           = 1'b1;
                ld_value_o          = {24'h0, shifted[7:0]};
                ld_onehot_o[LDV_BU] = 1'b1;
            end
            LD_H: begin
                is_load_o          = 1'b1;
                misaligned_o       = addr_lo_i[0];
                ld_value_o         = {{16{shifted[15]}}, shifted[15:0]};
                ld_onehot_o[LDV_H] = 1'b1;
            end
            LD_HU: begin
                is_load_o           = 1'b1;
                misaligned_o        = addr_lo_i[0];
                ld_value_o          = {16'h0, shifted[15:0]};
                ld_onehot_o[LDV_HU] = 1'b1;
            end
            LD_W: begin
                is_load_o          = 1'b1;
                misaligned_o       = |addr_lo_i;
                ld_value_o         = shifted;
                ld_onehot_o[LDV_W] = 1'b1;
            end
            ST_B: begin
                is_store_o         = 1'b1;
                wstrb_o            = 4'b0001 << addr_lo_i;
                wdata_o            = {4{st_data_i[7:0]}};
                st_onehot_o[STV_B] = 1'b1;
            end
            ST_H: begin
                is_store_o         = 1'b1;
                misaligned_o       = addr_lo_i[0];
                wstrb_o            = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o            = {2{st_data_i[15:0]}};
                st_onehot_o[STV_H] = 1'b1;
            end
            ST_W: begin
                is_store_o         = 1'b1;
                misaligned_o       = |addr_lo_i;
                wstrb_o            = 4'b1111;
                wdata_o            = st_data_i;
                st_onehot_o[STV_W] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: data-RAM access and load alignment
//
// Purpose: issues aligned loads/stores to the data-RAM port, waits for the
//          response, and presents writeback/commit info to MEM_WB with the
//          valid/ready stage handshake. Non-memory and misaligned ops pass
//          through combinationally.
// Ports:
//   clk, rst, flush                 clock, sync active-high reset, pipeline kill
//   ls_valid / ts_ready             upstream (EX_MEM) handshake
//   ts_valid / ns_ready             downstream (MEM_WB) handshake
//   ex_*                            instruction fields from EX_MEM
//   dreq_* / drsp_*                 data-RAM request and response
//   mem_*                           writeback info to MEM_WB
//   ld_valid/ld_paddr/st_valid/st_paddr/st_data   LSU commit info
//   ale                             address-misaligned flag

import mem_access_stage_pkg::*;

module mem_access_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ls_valid,
    output logic        ts_ready,
    input  logic        ns_ready,
    output logic        ts_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_inst,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_st_data,
    input  logic [4:0]  ex_rw_addr,
    input  logic        ex_rw_en,
    input  logic [3:0]  ex_mem_op,
    output logic        dreq_valid,
    input  logic        dreq_ready,
    output logic        dreq_we,
    output logic [31:0] dreq_addr,
    output logic [3:0]  dreq_wstrb,
    output logic [31:0] dreq_wdata,
    input  logic        drsp_valid,
    input  logic [31:0] drsp_rdata,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_inst,
    output logic [31:0] mem_rw_data,
    output logic [4:0]  mem_rw_addr,
    output logic        mem_rw_en,
    output logic        mem_ram_rd_en,
    output logic [7:0]  ld_valid,
    output logic [31:0] ld_paddr,
    output logic [7:0]  st_valid,
    output logic [31:0] st_paddr,
    output logic [31:0] st_data,
    output logic        ale
);

    mas_state_t  state_q, state_d;
    mem_out_t    res_q, res_d, out_sel;

    logic        is_load, is_store, misaligned;
    logic [3:0]  wstrb;
    logic [31:0] wdata, ld_value;
    logic [7:0]  ld_onehot, st_onehot;
    logic        ld_ok, st_ok, req_ok, use_regs, capture;

    lsu_align u_align (
        .mem_op_i     (mem_op_t'(ex_mem_op)),
        .addr_lo_i    (ex_result[1:0]),
        .st_data_i    (ex_st_data),
        .rdata_i      (drsp_rdata),
        .is_load_o    (is_load),
        .is_store_o   (is_store),
        .misaligned_o (misaligned),
        .wstrb_o      (wstrb),
        .wdata_o      (wdata),
        .ld_value_o   (ld_value),
        .ld_onehot_o  (ld_onehot),
        .st_onehot_o  (st_onehot)
    );

    assign ld_ok  = is_load && !misaligned;
    assign st_ok  = is_store && !misaligned;
    // Only an aligned, live, unflushed memory op touches the bus.
    assign req_ok = ls_valid && (ld_ok || st_ok) && !flush;

    // Result as seen this cycle; in WAIT it also carries the response data,
    // which is what gets latched for DONE.
    always_comb begin
        res_d           = '0;
        res_d.pc        = ex_pc;
        res_d.inst      = ex_inst;
        res_d.rw_addr   = ex_rw_addr;
        res_d.rw_en     = ex_rw_en && !misaligned;
        res_d.ram_rd_en = ld_ok;
        res_d.rw_data   = ld_ok ? ld_value : ex_result;
        res_d.ld_valid  = ld_ok ? ld_onehot : 8'h00;
        res_d.ld_paddr  = ld_ok ? ex_result : 32'h0;
        res_d.st_valid  = st_ok ? st_onehot : 8'h00;
        res_d.st_paddr  = st_ok ? ex_result : 32'h0;
        res_d.st_data   = st_ok ? wdata : 32'h0;
    end

    always_comb begin
        state_d    = state_q;
        ts_valid   = 1'b0;
        ts_ready   = 1'b0;
        dreq_valid = 1'b0;
        use_regs   = 1'b0;
        capture    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_ok) begin
                    dreq_valid = 1'b1;
                    if (dreq_ready) begin
                        state_d = S_WAIT;
                    end
                end else begin
                    ts_valid = ls_valid;
                    ts_ready = ns_ready;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    // A response coincident with the flush is the one we would
                    // otherwise have to drain, so there is nothing left to wait for.
                    state_d = drsp_valid ? S_IDLE : S_DRAIN;
                end else if (drsp_valid) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                use_regs = 1'b1;
                ts_valid = 1'b1;
                ts_ready = ns_ready;
                if (flush || ns_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (drsp_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            ts_valid   = 1'b0;
            ts_ready   = 1'b0;
            dreq_valid = 1'b0;
            capture    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                res_q <= res_d;
            end
        end
    end

    always_comb begin
        out_sel = res_d;
        if (rst) begin
            out_sel = '0;
        end else if (use_regs) begin
            out_sel = res_q;
        end
    end

    assign mem_pc        = out_sel.pc;
    assign mem_inst      = out_sel.inst;
    assign mem_rw_data   = out_sel.rw_data;
    assign mem_rw_addr   = out_sel.rw_addr;
    assign mem_rw_en     = out_sel.rw_en;
    assign mem_ram_rd_en = out_sel.ram_rd_en;
    assign ld_valid      = out_sel.ld_valid;
    assign ld_paddr      = out_sel.ld_paddr;
    assign st_valid      = out_sel.st_valid;
    assign st_paddr      = out_sel.st_paddr;
    assign st_data       = out_sel.st_data;

    // The registered result is always aligned, so ale only reflects the live input.
    assign ale        = !rst && !use_regs && ls_valid && misaligned;
    assign dreq_we    = !rst && is_store;
    assign dreq_addr  = rst ? 32'h0 : word_addr(ex_result);
    assign dreq_wstrb = rst ? 4'h0 : wstrb;
    assign dreq_wdata = rst ? 32'h0 : wdata;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage

import mem_access_stage_pkg::*;

module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst, flush, ls_valid, ns_ready;
    logic [31:0] ex_pc, ex_inst, ex_result, ex_st_data;
    logic [4:0]  ex_rw_addr;
    logic        ex_rw_en;
    logic [3:0]  ex_mem_op;
    logic        dreq_ready, drsp_valid;
    logic [31:0] drsp_rdata;

    logic        ts_ready, ts_valid, dreq_valid, dreq_we;
    logic [31:0] dreq_addr, dreq_wdata;
    logic [3:0]  dreq_wstrb;
    logic [31:0] mem_pc, mem_inst, mem_rw_data, ld_paddr, st_paddr, st_data;
    logic [4:0]  mem_rw_addr;
    logic        mem_rw_en, mem_ram_rd_en, ale;
    logic [7:0]  ld_valid, st_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .ls_valid(ls_valid),
        .ts_ready(ts_ready), .ns_ready(ns_ready), .ts_valid(ts_valid),
        .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_result(ex_result),
        .ex_st_data(ex_st_data), .ex_rw_addr(ex_rw_addr), .ex_rw_en(ex_rw_en),
        .ex_mem_op(ex_mem_op), .dreq_valid(dreq_valid), .dreq_ready(dreq_ready),
        .dreq_we(dreq_we), .dreq_addr(dreq_addr), .dreq_wstrb(dreq_wstrb),
        .dreq_wdata(dreq_wdata), .drsp_valid(drsp_valid), .drsp_rdata(drsp_rdata),
        .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_rw_data(mem_rw_data),
        .mem_rw_addr(mem_rw_addr), .mem_rw_en(mem_rw_en),
        .mem_ram_rd_en(mem_ram_rd_en), .ld_valid(ld_valid), .ld_paddr(ld_paddr),
        .st_valid(st_valid), .st_paddr(st_paddr), .st_data(st_data), .ale(ale)
    );

    typedef struct {
        mem_op_t     op;
        logic [31:0] addr, sdata, rdata;
        logic        rw_en;
        logic [31:0] exp_data;
        logic [7:0]  exp_ld, exp_st;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic        exp_ale, exp_wen, exp_rd, req;
        int          rdy, lat, stall;
        logic [31:0] pc;
        logic [4:0]  rw_addr;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];
    vec_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input mem_op_t op, input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] rdata, input logic rw_en, input logic [31:0] exp_data,
                                input logic [7:0] exp_ld, input logic [7:0] exp_st, input logic [3:0] exp_wstrb,
                                input logic [31:0] exp_wdata, input logic exp_ale, input logic exp_wen,
                                input logic exp_rd, input logic req, input int rdy, input int lat, input int stall);
        vec_t v;
        v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.rw_en = rw_en;
        v.exp_data = exp_data; v.exp_ld = exp_ld; v.exp_st = exp_st;
        v.exp_wstrb = exp_wstrb; v.exp_wdata = exp_wdata; v.exp_ale = exp_ale;
        v.exp_wen = exp_wen; v.exp_rd = exp_rd; v.req = req;
        v.rdy = rdy; v.lat = lat; v.stall = stall;
        v.pc = 32'h0; v.rw_addr = 5'd0;
        return v;
    endfunction

    // Scoreboard: every accepted output handshake is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && ts_valid && ns_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: ts_valid=1 with pc 0x%08h, expected no output", mem_pc);
            end else begin
                vec_t v;
                v = exp_q.pop_front();
                chk("out_pc", mem_pc, v.pc);
                chk("out_inst", mem_inst, ~v.pc);
                chk("out_rw_data", mem_rw_data, v.exp_data);
                chk("out_rw_addr", 32'(mem_rw_addr), 32'(v.rw_addr));
                chk("out_rw_en", 32'(mem_rw_en), 32'(v.exp_wen));
                chk("out_ram_rd_en", 32'(mem_ram_rd_en), 32'(v.exp_rd));
                chk("out_ld_valid", 32'(ld_valid), 32'(v.exp_ld));
                chk("out_st_valid", 32'(st_valid), 32'(v.exp_st));
                chk("out_ld_paddr", ld_paddr, (v.exp_ld != 0) ? v.addr : 32'h0);
                chk("out_st_paddr", st_paddr, (v.exp_st != 0) ? v.addr : 32'h0);
                chk("out_st_data", st_data, (v.exp_st != 0) ? v.exp_wdata : 32'h0);
                chk("out_ale", 32'(ale), 32'(v.exp_ale));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        ls_valid   = 1'b1;
        ex_pc      = v.pc;
        ex_inst    = ~v.pc;
        ex_result  = v.addr;
        ex_st_data = v.sdata;
        ex_rw_addr = v.rw_addr;
        ex_rw_en   = v.rw_en;
        ex_mem_op  = v.op;
        dreq_ready = 1'b0;
        drsp_valid = 1'b0;
        ns_ready   = (v.stall == 0);
        exp_q.push_back(v);
        if (v.req) begin
            for (int c = 0; c <= v.rdy; c++) begin
                @(negedge clk);
                chk("req_valid", 32'(dreq_valid), 32'd1);
                chk("req_addr", dreq_addr, {v.addr[31:2], 2'b00});
                chk("req_we", 32'(dreq_we), 32'(v.exp_st != 0));
                if (v.exp_st != 0) begin
                    chk("req_wstrb", 32'(dreq_wstrb), 32'(v.exp_wstrb));
                    chk("req_wdata", dreq_wdata, v.exp_wdata);
                end
                chk("req_ts_valid", 32'(ts_valid), 32'd0);
                chk("req_ts_ready", 32'(ts_ready), 32'd0);
                if (c == v.rdy) dreq_ready = 1'b1;
            end
            @(posedge clk); #1;
            dreq_ready = 1'b0;
            for (int c = 0; c < v.lat; c++) begin
                drsp_rdata = $urandom;
                @(negedge clk);
                chk("wait_req_valid", 32'(dreq_valid), 32'd0);
                chk("wait_ts_valid", 32'(ts_valid), 32'd0);
                @(posedge clk); #1;
            end
            drsp_valid = 1'b1;
            drsp_rdata = v.rdata;
            @(negedge clk);
            chk("rsp_ts_valid", 32'(ts_valid), 32'd0);
            @(posedge clk); #1;
            drsp_valid = 1'b0;
            drsp_rdata = $urandom;
            for (int c = 0; c < v.stall; c++) begin
                @(negedge clk);
                chk("stall_ts_valid", 32'(ts_valid), 32'd1);
                chk("stall_ts_ready", 32'(ts_ready), 32'd0);
                chk("stall_rw_data", mem_rw_data, v.exp_data);
                @(posedge clk); #1;
            end
            ns_ready = 1'b1;
            @(negedge clk);
            chk("done_ts_ready", 32'(ts_ready), 32'd1);
            chk("done_req_valid", 32'(dreq_valid), 32'd0);
        end else begin
            @(negedge clk);
            chk("pass_ts_valid", 32'(ts_valid), 32'd1);
            chk("pass_ts_ready", 32'(ts_ready), 32'd1);
            chk("pass_req_valid", 32'(dreq_valid), 32'd0);
        end
        @(posedge clk); #1;
        ls_valid  = 1'b0;
        ex_mem_op = NONE;
    endtask

    task automatic flush_seq(input bit same_cycle);
        @(posedge clk); #1;
        ls_valid   = 1'b1;
        ex_pc      = 32'h1c000800;
        ex_inst    = 32'h0;
        ex_mem_op  = LD_W;
        ex_result  = 32'h300;
        ex_rw_en   = 1'b1;
        ns_ready   = 1'b1;
        dreq_ready = 1'b1;
        @(negedge clk);
        chk("flush_req_valid", 32'(dreq_valid), 32'd1);
        @(posedge clk); #1;
        dreq_ready = 1'b0;
        flush      = 1'b1;
        ls_valid   = 1'b0;
        ex_mem_op  = NONE;
        if (same_cycle) begin
            drsp_valid = 1'b1;
            drsp_rdata = 32'h11111111;
        end
        @(negedge clk);
        chk("flush_ts_valid", 32'(ts_valid), 32'd0);
        @(posedge clk); #1;
        flush      = 1'b0;
        drsp_valid = 1'b0;
        if (!same_cycle) begin
            @(negedge clk);
            chk("drain_ts_valid", 32'(ts_valid), 32'd0);
            chk("drain_ts_ready", 32'(ts_ready), 32'd0);
            chk("drain_req_valid", 32'(dreq_valid), 32'd0);
            @(posedge clk); #1;
            drsp_valid = 1'b1;
            drsp_rdata = 32'h22222222;
            @(negedge clk);
            chk("drain_rsp_ts_valid", 32'(ts_valid), 32'd0);
            chk("drain_rsp_ts_ready", 32'(ts_ready), 32'd0);
            @(posedge clk); #1;
            drsp_valid = 1'b0;
        end
        @(negedge clk);
        chk("after_flush_idle_ready", 32'(ts_ready), 32'd1);
        chk("after_flush_ts_valid", 32'(ts_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected simulation end");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0]  = mk(NONE,  32'h12345678, 32'h0,        32'h0,        1'b1, 32'h12345678, 8'h00, 8'h00, 4'h0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        vecs[1]  = mk(LD_B,  32'h00000103, 32'h0,        32'h80AABBCC, 1'b1, 32'hFFFFFF80, 8'h01, 8'h00, 4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 0);
        vecs[2]  = mk(LD_HU, 32'h00000102, 32'h0,        32'hBEEF1234, 1'b1, 32'h0000BEEF, 8'h08, 8'h00, 4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 0, 1, 0);
        vecs[3]  = mk(ST_H,  32'h00000202, 32'h00001234, 32'h0,        1'b0, 32'h00000202, 8'h00, 8'h02, 4'hC, 32'h12341234, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0, 0);
        vecs[4]  = mk(LD_W,  32'h00000101, 32'h0,        32'h0,        1'b1, 32'h00000101, 8'h00, 8'h00, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        vecs[5]  = mk(ST_B,  32'h00000101, 32'hFFFFFFA5, 32'h0,        1'b0, 32'h00000101, 8'h00, 8'h01, 4'h2, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b1, 1, 2, 0);
        vecs[6]  = mk(LD_H,  32'h00000002, 32'h0,        32'h80010000, 1'b1, 32'hFFFF8001, 8'h04, 8'h00, 4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 0);
        vecs[7]  = mk(LD_BU, 32'h00000001, 32'h0,        32'h0000F000, 1'b1, 32'h000000F0, 8'h02, 8'h00, 4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 2, 1, 0);
        vecs[8]  = mk(ST_W,  32'h00000400, 32'hDEADBEEF, 32'h0,        1'b0, 32'h00000400, 8'h00, 8'h04, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        vecs[9]  = mk(LD_W,  32'h00000404, 32'h0,        32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 8'h10, 8'h00, 4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 2);
        vecs[10] = mk(ST_H,  32'h00000203, 32'h00005678, 32'h0,        1'b0, 32'h00000203, 8'h00, 8'h00, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        vecs[11] = mk(LD_B,  32'h00000000, 32'h0,        32'h0000007F, 1'b1, 32'h0000007F, 8'h01, 8'h00, 4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 0, 3, 0);
        for (int i = 0; i < NV; i++) begin
            vecs[i].pc      = 32'h1c000000 + 32'(i * 4);
            vecs[i].rw_addr = 5'(i + 1);
        end

        // Reset with live, flushed inputs: every output must read zero.
        rst = 1'b1; flush = 1'b1; ls_valid = 1'b1; ns_ready = 1'b1;
        ex_pc = 32'h1c000000; ex_inst = 32'h1; ex_result = 32'h100; ex_st_data = 32'h0;
        ex_rw_addr = 5'd3; ex_rw_en = 1'b1; ex_mem_op = LD_W;
        dreq_ready = 1'b1; drsp_valid = 1'b0; drsp_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ts_valid", 32'(ts_valid), 32'd0);
        chk("rst_ts_ready", 32'(ts_ready), 32'd0);
        chk("rst_dreq_valid", 32'(dreq_valid), 32'd0);
        chk("rst_dreq_addr", dreq_addr, 32'h0);
        chk("rst_rw_data", mem_rw_data, 32'h0);
        chk("rst_ld_valid", 32'(ld_valid), 32'd0);
        chk("rst_ale", 32'(ale), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; ls_valid = 1'b0; ex_mem_op = NONE;
        dreq_ready = 1'b0; ex_result = 32'h0;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
        end

        // Stray response while idle must not disturb the FSM.
        @(posedge clk); #1;
        drsp_valid = 1'b1;
        drsp_rdata = 32'h33333333;
        @(posedge clk); #1;
        drsp_valid = 1'b0;
        run_vec(vecs[0]);

        flush_seq(1'b0);
        run_vec(vecs[0]);
        flush_seq(1'b1);
        run_vec(vecs[1]);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
